// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: holds PLL reset, waits for lock with bounded retries, qualifies lock before releasing sys_reset_n. Optional PLL_SUPERV_LOSS_COUNT_EN adds loss_cnt.
// Latency: sys_reset_n rises SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges after lock is first sampled; falls SYNC_STAGES+1 edges after lock loss.
// Backpressure: none; every output is a flop in the clk domain, no input-to-output combinational path.
module pll_lock_supervisor #(
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT       = 65535,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] retry_cnt
`ifdef PLL_SUPERV_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_cnt
`endif
);

    localparam int unsigned MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [7:0]             retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_rst_n_q, sys_rst_n_d;
    logic                   fail_q, fail_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    // pll_locked comes from the PLL's own lock detector, asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (restart) begin
            state_d = ST_HOLD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TMO_LAST) begin
                        if (retry_q == RETRY_LIMIT) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_HOLD;
                            retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                        end
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) state_d = ST_HOLD;
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end

        // One shared counter; it restarts from zero whenever the state changes or restart hits
        if (restart || (state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAIL)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_comb begin
        pll_rst_d   = (state_d == ST_HOLD) || (state_d == ST_FAIL);
        sys_rst_n_d = (state_d == ST_RUN);
        fail_d      = (state_d == ST_FAIL);
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_rst_n_q;
    assign fail        = fail_q;
    assign state       = state_q;
    assign retry_cnt   = retry_q;

`ifdef PLL_SUPERV_LOSS_COUNT_EN
    logic [7:0] loss_q;

    // Only lock loss counts; a restart issued while in RUN is not a loss
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_q <= '0;
        end else if ((state_q == ST_RUN) && !restart && !locked_s && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a phase/countdown model checked every cycle, plus hand-computed milestones.
module tb_pll_lock_supervisor;

    localparam int HOLD_N = 4;
    localparam int TMO_N  = 32;
    localparam int STB_N  = 8;
    localparam int MAXR   = 2;
    localparam int SYNC_N = 2;
    localparam int LIMIT  = 500;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       fail;
    logic [2:0] state;
    logic [7:0] retry_cnt;
`ifdef PLL_SUPERV_LOSS_COUNT_EN
    logic [7:0] loss_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES   (HOLD_N),
        .LOCK_TIMEOUT      (TMO_N),
        .LOCK_STABLE_CYCLES(STB_N),
        .MAX_RETRIES       (MAXR),
        .SYNC_STAGES       (SYNC_N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .sys_reset_n(sys_reset_n),
        .fail       (fail),
        .state      (state),
        .retry_cnt  (retry_cnt)
`ifdef PLL_SUPERV_LOSS_COUNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: phase 0..4 (HOLD..FAIL), a countdown of cycles left in the phase,
    // and a queue holding the lock samples still in flight through the synchroniser.
    int m_ph, m_rem, m_retry, m_loss;
    bit m_q[$];

    task automatic m_reset();
        m_ph    = 0;
        m_rem   = HOLD_N;
        m_retry = 0;
        m_loss  = 0;
        m_q.delete();
        repeat (SYNC_N) m_q.push_back(1'b0);
    endtask

    task automatic m_step();
        bit ls;
        ls = m_q.pop_front();
        m_q.push_back(pll_locked);
        if (restart) begin
            m_ph    = 0;
            m_rem   = HOLD_N;
            m_retry = 0;
        end else begin
            case (m_ph)
                0: begin
                    m_rem--;
                    if (m_rem == 0) begin m_ph = 1; m_rem = TMO_N; end
                end
                1: begin
                    if (ls) begin
                        m_ph = 2; m_rem = STB_N;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            if (m_retry == MAXR) begin
                                m_ph = 4;
                            end else begin
                                m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                                m_ph = 0; m_rem = HOLD_N;
                            end
                        end
                    end
                end
                2: begin
                    if (!ls) begin
                        m_ph = 1; m_rem = TMO_N;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) begin m_ph = 3; m_retry = 0; end
                    end
                end
                3: begin
                    if (!ls) begin
                        m_ph = 0; m_rem = HOLD_N;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_state", int'(state), m_ph);
            chk("cyc_pll_rst", int'(pll_rst), int'(m_ph == 0 || m_ph == 4));
            chk("cyc_sys_reset_n", int'(sys_reset_n), int'(m_ph == 3));
            chk("cyc_fail", int'(fail), int'(m_ph == 4));
            chk("cyc_retry_cnt", int'(retry_cnt), m_retry);
`ifdef PLL_SUPERV_LOSS_COUNT_EN
            chk("cyc_loss_cnt", int'(loss_cnt), m_loss);
`endif
        end
    end

    task automatic edge_();
        @(posedge clk);
        #1;
    endtask

    task automatic count_while(input int st, output int n);
        n = 0;
        while (int'(state) == st && n < LIMIT) begin edge_(); n++; end
    endtask

    task automatic wait_state(input int st, output int n);
        n = 0;
        while (int'(state) != st && n < LIMIT) begin edge_(); n++; end
    endtask

    task automatic wait_sys(input logic v, output int n);
        n = 0;
        while (sys_reset_n != v && n < LIMIT) begin edge_(); n++; end
    endtask

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) edge_();
        chk("rst_state", int'(state), 0);
        chk("rst_pll_rst", int'(pll_rst), 1);
        chk("rst_sys_reset_n", int'(sys_reset_n), 0);
        chk("rst_fail", int'(fail), 0);
        chk("rst_retry", int'(retry_cnt), 0);
        reset_n = 1'b1;

        // Normal bring-up
        count_while(0, n);       chk("s1_hold_len", n, 4);
        repeat (6) edge_();
        pll_locked = 1'b1;
        wait_sys(1'b1, n);       chk("s1_lock_to_run_edges", n, 11);
        chk("s1_state", int'(state), 3);
        chk("s1_retry", int'(retry_cnt), 0);
        chk("s1_model_phase", m_ph, 3);

        // Loss in RUN
        pll_locked = 1'b0;
        wait_sys(1'b0, n);       chk("s5_loss_edges", n, 3);
        chk("s5_state", int'(state), 0);
        chk("s5_pll_rst", int'(pll_rst), 1);
        count_while(0, n);       chk("s5_hold_len", n, 4);
`ifdef PLL_SUPERV_LOSS_COUNT_EN
        chk("s5_loss_cnt", int'(loss_cnt), 1);
`endif

        // Timeouts to FAIL
        count_while(1, n);       chk("s3_wait1_len", n, 32);
        chk("s3_retry1", int'(retry_cnt), 1);
        count_while(0, n);       chk("s3_hold1_len", n, 4);
        count_while(1, n);       chk("s3_wait2_len", n, 32);
        chk("s3_retry2", int'(retry_cnt), 2);
        count_while(0, n);       chk("s3_hold2_len", n, 4);
        count_while(1, n);       chk("s3_wait3_len", n, 32);
        chk("s3_state", int'(state), 4);
        chk("s3_fail", int'(fail), 1);
        chk("s3_pll_rst", int'(pll_rst), 1);
        chk("s3_retry_final", int'(retry_cnt), 2);
        chk("s3_model_phase", m_ph, 4);
        repeat (5) edge_();
        chk("s3_fail_sticky", int'(state), 4);

        // Restart from FAIL, then normal bring-up
        restart = 1'b1;
        edge_();
        restart = 1'b0;
        chk("s4_state", int'(state), 0);
        chk("s4_fail", int'(fail), 0);
        chk("s4_retry", int'(retry_cnt), 0);
        chk("s4_pll_rst", int'(pll_rst), 1);
        count_while(0, n);       chk("s4_hold_len", n, 4);
        pll_locked = 1'b1;
        wait_sys(1'b1, n);       chk("s4_lock_to_run_edges", n, 11);
        chk("s4_run", int'(state), 3);

        // Lock glitch during STABLE
        pll_locked = 1'b0;
        wait_state(0, n);        chk("s2_loss_to_hold", n, 3);
        pll_locked = 1'b1;
        wait_state(2, n);        chk("s2_hold_to_stable", n, 5);
        repeat (5) edge_();
        pll_locked = 1'b0;
        edge_();
        pll_locked = 1'b1;
        wait_state(1, n);        chk("s2_back_to_wait", n, 2);
        chk("s2_retry_unchanged", int'(retry_cnt), 0);
        wait_state(2, n);        chk("s2_restable", n, 1);
        count_while(2, n);       chk("s2_stable_len", n, 8);
        chk("s2_run", int'(state), 3);

        // Restart collides with the final timeout
        pll_locked = 1'b0;
        wait_state(0, n);        chk("s6_to_hold", n, 3);
        count_while(0, n);       chk("s6_hold1", n, 4);
        count_while(1, n);       chk("s6_wait1", n, 32);
        count_while(0, n);       chk("s6_hold2", n, 4);
        count_while(1, n);       chk("s6_wait2", n, 32);
        chk("s6_retry2", int'(retry_cnt), 2);
        count_while(0, n);       chk("s6_hold3", n, 4);
        repeat (31) edge_();
        chk("s6_pre_wait", int'(state), 1);
        restart = 1'b1;
        edge_();
        restart = 1'b0;
        chk("s6_state", int'(state), 0);
        chk("s6_fail", int'(fail), 0);
        chk("s6_retry", int'(retry_cnt), 0);
        chk("s6_model_retry", m_retry, 0);
        count_while(0, n);       chk("s6_hold_after", n, 4);

        // Asynchronous reset in RUN
        pll_locked = 1'b1;
        wait_state(3, n);
        chk("ar_run", int'(state), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_pll_rst", int'(pll_rst), 1);
        chk("ar_sys_reset_n", int'(sys_reset_n), 0);
        chk("ar_state", int'(state), 0);
        repeat (2) edge_();
        reset_n = 1'b1;
        repeat (3) edge_();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the fabric PLL. Holds the PLL in reset after power-up, waits for lock with a timeout, and retries a bounded number of times.
- Requires lock to stay stable before releasing the downstream system reset.
- Sits beside the PLL instance and runs on the free-running 50 MHz reference clock, never on a PLL output.
- Downstream logic on PLL output clocks resynchronises sys_reset_n locally.

Parameters:
RST_HOLD_CYCLES, 16, cycles pll_rst is held high on every HOLD entry (>=1)
LOCK_TIMEOUT, 65535, cycles allowed in WAIT_LOCK before a retry (>=2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before RUN (>=1)
MAX_RETRIES, 3, lock timeouts tolerated before FAIL (0..255)
SYNC_STAGES, 2, flops on the pll_locked synchroniser (>=2)

Ports:
clk  input  1  free-running reference clock (same net as the PLL refclk)
reset_n  input  1  asynchronous active-low reset
pll_locked  input  1  PLL locked, asynchronous to clk
restart  input  1  single-cycle pulse; forces a full re-sequence
pll_rst  output  1  active-high reset to the PLL
sys_reset_n  output  1  active-low system reset release, clk domain
fail  output  1  sticky; lock never achieved within the retry budget
state  output  3  HOLD=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4
retry_cnt  output  8  lock timeouts since the last RUN or restart

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=HOLD; pll_rst=1; sys_reset_n=0; fail=0; retry_cnt=0.
  - Cycle counter = 0; synchroniser flops = 0.
- All outputs are registered. No combinational path from any input to any output.
- pll_locked passes through SYNC_STAGES flops to give locked_s. Only locked_s is used.
- Single cycle counter, width clog2 of the largest count parameter. It is cleared on every state change.
- HOLD:
  - pll_rst=1, sys_reset_n=0.
  - Counter increments each cycle. When counter==RST_HOLD_CYCLES-1, go to WAIT_LOCK. pll_rst falls on that same edge.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Otherwise, when counter==LOCK_TIMEOUT-1:
    - retry_cnt==MAX_RETRIES: go to FAIL.
    - otherwise: retry_cnt+1 and go to HOLD.
- STABLE:
  - If locked_s=0, go to WAIT_LOCK. retry_cnt is unchanged and the timeout restarts from 0.
  - Else when counter==LOCK_STABLE_CYCLES-1: go to RUN, sys_reset_n<=1 and retry_cnt<=0 on the same edge.
- RUN:
  - sys_reset_n=1.
  - locked_s=0: go to HOLD and sys_reset_n<=0 on the same edge. pll_rst<=1 on that edge too.
- FAIL:
  - pll_rst=1, sys_reset_n=0, fail=1. Stays here until restart or reset_n.
- restart=1 in any state: go to HOLD, retry_cnt<=0, fail<=0, counter<=0. restart has priority over every other transition in that cycle.
- Latency: pll_locked is first sampled high while in WAIT_LOCK. sys_reset_n rises exactly SYNC_STAGES+LOCK_STABLE_CYCLES+1 edges later, provided the lock is held.
- Lock-loss latency: pll_locked falls in RUN. sys_reset_n falls SYNC_STAGES+1 edges later.
- retry_cnt saturates at 255. It never wraps.
- Reset mid-operation: reset_n low asynchronously forces the reset values immediately, including pll_rst=1.

Optional Feature:
PLL_SUPERV_LOSS_COUNT_EN
- Defined:
  - Adds output loss_cnt[7:0], reset 0.
  - Increments on each RUN->HOLD transition caused by locked_s=0.
  - Saturates at 255. Cleared only by reset_n; restart does not clear it.
- Undefined: no port and no logic. Behaviour is otherwise identical.

Test Plan:
All scenarios use RST_HOLD_CYCLES=4, LOCK_TIMEOUT=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
1. Normal bring-up: release reset_n; assert pll_locked 10 cycles later and hold it -> pll_rst high exactly 4 cycles; sys_reset_n rises 11 edges after locked is first sampled; state=3; retry_cnt=0.
2. Lock glitch: in STABLE, drop pll_locked 1 cycle at counter=5 -> return to WAIT_LOCK; RUN reached only after 8 further stable cycles; retry_cnt unchanged.
3. Timeouts to FAIL: hold pll_locked low -> three 32-cycle WAIT_LOCK windows, each separated by 4-cycle pll_rst pulses; retry_cnt goes 1, 2; then state=4, fail=1, pll_rst=1.
4. Restart from FAIL: pulse restart, then provide lock -> fail=0, retry_cnt=0, normal sequence as in scenario 1.
5. Loss in RUN: drop pll_locked -> sys_reset_n low 3 edges later; pll_rst high 4 cycles; loss_cnt=1 when PLL_SUPERV_LOSS_COUNT_EN is defined.
6. Restart and timeout collide: restart asserted on the same cycle as a WAIT_LOCK timeout with retry_cnt=2 -> state=HOLD, fail stays 0, retry_cnt=0.
